// File: rtl/mem_wb_load_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_load_stage : MEM/WB pipeline register with load extraction/extension.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wb_load_stage #(
  parameter int B = 32,
  parameter int R = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_enable,
  input  logic         i_flush,
  input  logic         i_reg_write,
  input  logic         i_mem_to_reg,
  input  logic [1:0]   i_load_size,
  input  logic         i_load_unsigned,
  input  logic [R-1:0] i_rd_addr,
  input  logic [B-1:0] i_alu_result,
  input  logic [B-1:0] i_mem_data,
  output logic         o_reg_write,
  output logic [R-1:0] o_rd_addr,
  output logic [B-1:0] o_wb_data,
  output logic         o_misaligned
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;

  logic         reg_write_q,     reg_write_d;
  logic         mem_to_reg_q,    mem_to_reg_d;
  logic [1:0]   load_size_q,     load_size_d;
  logic         load_unsigned_q, load_unsigned_d;
  logic [R-1:0] rd_addr_q,       rd_addr_d;
  logic [B-1:0] alu_result_q,    alu_result_d;
  logic [1:0]   off_q,           off_d;
  logic         held_q,          held_d;
  logic [B-1:0] shadow_q,        shadow_d;

  logic [B-1:0] w_md;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [B-1:0] w_load;
  logic         w_misaligned;

  always_comb begin
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    load_size_d     = load_size_q;
    load_unsigned_d = load_unsigned_q;
    rd_addr_d       = rd_addr_q;
    alu_result_d    = alu_result_q;
    off_d           = off_q;
    held_d          = held_q;
    shadow_d        = shadow_q;
    if (i_flush) begin
      reg_write_d     = 1'b0;
      mem_to_reg_d    = 1'b0;
      load_size_d     = 2'b00;
      load_unsigned_d = 1'b0;
      rd_addr_d       = '0;
      alu_result_d    = '0;
      off_d           = 2'b00;
      held_d          = 1'b0;
      shadow_d        = '0;
    end else if (i_enable) begin
      reg_write_d     = i_reg_write;
      mem_to_reg_d    = i_mem_to_reg;
      load_size_d     = i_load_size;
      load_unsigned_d = i_load_unsigned;
      rd_addr_d       = i_rd_addr;
      alu_result_d    = i_alu_result;
      off_d           = i_alu_result[1:0];
      held_d          = 1'b0;
    end else if (!held_q) begin
      // data_mem keeps re-reading; freeze the word from the first stalled cycle
      shadow_d = i_mem_data;
      held_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      load_size_q     <= 2'b00;
      load_unsigned_q <= 1'b0;
      rd_addr_q       <= '0;
      alu_result_q    <= '0;
      off_q           <= 2'b00;
      held_q          <= 1'b0;
      shadow_q        <= '0;
    end else begin
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      load_size_q     <= load_size_d;
      load_unsigned_q <= load_unsigned_d;
      rd_addr_q       <= rd_addr_d;
      alu_result_q    <= alu_result_d;
      off_q           <= off_d;
      held_q          <= held_d;
      shadow_q        <= shadow_d;
    end
  end

  always_comb begin
    w_md   = held_q ? shadow_q : i_mem_data;
    w_byte = w_md[{off_q, 3'b000} +: 8];
    w_half = off_q[1] ? w_md[31:16] : w_md[15:0];
    case (load_size_q)
      c_size_byte: w_load = {{(B-8){w_byte[7] & ~load_unsigned_q}}, w_byte};
      c_size_half: w_load = {{(B-16){w_half[15] & ~load_unsigned_q}}, w_half};
      default:     w_load = w_md;
    endcase
    w_misaligned = 1'b0;
    if (mem_to_reg_q) begin
      if (load_size_q == c_size_half)
        w_misaligned = off_q[0];
      else if (load_size_q[1])
        w_misaligned = (off_q != 2'b00);
    end
  end

  assign o_wb_data    = mem_to_reg_q ? w_load : alu_result_q;
  assign o_misaligned = w_misaligned;
  assign o_reg_write  = reg_write_q & ~w_misaligned;
  assign o_rd_addr    = rd_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_load_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_load_stage : directed + random checks against a behavioural model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_load_stage;

  logic        clk = 1'b0;
  logic        rst, en, fl, rw, mtr, uns;
  logic [1:0]  sz;
  logic [4:0]  rd;
  logic [31:0] alu, mem;
  logic        o_rw, o_mis;
  logic [4:0]  o_rd;
  logic [31:0] o_wb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_load_stage #(.B(32), .R(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
    .i_reg_write(rw), .i_mem_to_reg(mtr), .i_load_size(sz),
    .i_load_unsigned(uns), .i_rd_addr(rd), .i_alu_result(alu),
    .i_mem_data(mem), .o_reg_write(o_rw), .o_rd_addr(o_rd),
    .o_wb_data(o_wb), .o_misaligned(o_mis)
  );

  // Reference: the instruction currently in WB and the memory word it sees
  logic        m_rw, m_mtr, m_uns, m_frozen;
  logic [1:0]  m_sz;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [1:0] s, input logic u,
                                      input int unsigned off, input logic [31:0] w);
    longint unsigned v;
    if (s == 2'd0) begin
      v = (longint'(w) >> (8 * off)) % 256;
      if (!u && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (s == 2'd1) begin
      v = (off >= 2) ? (longint'(w) / 65536) : (longint'(w) % 65536);
      if (!u && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  task automatic check_outputs(input string tag);
    int unsigned off;
    logic [31:0] w, exp_wb;
    logic        exp_mis;
    off     = m_alu % 4;
    w       = m_frozen ? m_word : mem;
    exp_mis = m_mtr && ((m_sz == 2'd1 && off % 2 == 1) || (m_sz >= 2'd2 && off != 0));
    exp_wb  = m_mtr ? fmt(m_sz, m_uns, off, w) : m_alu;
    chk({tag, ".wb"},  o_wb, exp_wb);
    chk({tag, ".we"},  {31'd0, o_rw}, {31'd0, m_rw && !exp_mis});
    chk({tag, ".mis"}, {31'd0, o_mis}, {31'd0, exp_mis});
    chk({tag, ".rd"},  {27'd0, o_rd}, {27'd0, m_rd});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst || fl) begin
      {m_rw, m_mtr, m_uns, m_frozen, m_sz, m_rd, m_alu, m_word} = '0;
    end else if (en) begin
      m_rw = rw; m_mtr = mtr; m_uns = uns; m_sz = sz; m_rd = rd; m_alu = alu;
      m_frozen = 1'b0;
    end else if (!m_frozen) begin
      m_word   = mem;
      m_frozen = 1'b1;
    end
    #1;
  endtask

  task automatic set_instr(input logic r, input logic m, input logic [1:0] s,
                           input logic u, input logic [4:0] d, input logic [31:0] a);
    rw = r; mtr = m; sz = s; uns = u; rd = d; alu = a;
  endtask

  initial begin
    {m_rw, m_mtr, m_uns, m_frozen, m_sz, m_rd, m_alu, m_word} = '0;
    rst = 1'b1; en = 1'b1; fl = 1'b0; mem = 32'h0;
    set_instr(1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Reset with enable high and live inputs clears a loaded entry
    set_instr(1'b1, 1'b0, 2'd2, 1'b0, 5'd7, 32'h1234_5678);
    tick();
    rst = 1'b1; set_instr(1'b1, 1'b1, 2'd2, 1'b1, 5'd9, 32'hFFFF_FFF0); mem = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; set_instr(1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    chk("rst.wb", o_wb, 32'h0);
    chk("rst.we", {31'd0, o_rw}, 32'd0);
    chk("rst.rd", {27'd0, o_rd}, 32'd0);
    chk("rst.mis", {31'd0, o_mis}, 32'd0);

    // LB signed at offset 2
    set_instr(1'b1, 1'b1, 2'd0, 1'b0, 5'd3, 32'h0000_0002);
    tick();
    mem = 32'h1280_3456; set_instr(1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0); #1;
    chk("lb.wb", o_wb, 32'hFFFF_FF80);
    chk("lb.we", {31'd0, o_rw}, 32'd1);
    check_outputs("lb");

    // LHU at offset 2
    set_instr(1'b1, 1'b1, 2'd1, 1'b1, 5'd4, 32'h0000_0002);
    tick();
    mem = 32'hBEEF_1234; #1;
    chk("lhu.wb", o_wb, 32'h0000_BEEF);
    check_outputs("lhu");

    // Misaligned LW
    set_instr(1'b1, 1'b1, 2'd2, 1'b0, 5'd5, 32'h0000_0001);
    tick();
    mem = 32'hAAAA_5555; #1;
    chk("lwmis.mis", {31'd0, o_mis}, 32'd1);
    chk("lwmis.we", {31'd0, o_rw}, 32'd0);
    check_outputs("lwmis");

    // LW followed by a 3-cycle stall while memory data changes
    set_instr(1'b1, 1'b1, 2'd2, 1'b0, 5'd6, 32'h0000_0010);
    tick();
    en = 1'b0; mem = 32'hCAFE_F00D; #1;
    chk("stall0.wb", o_wb, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      mem = 32'h1111_1111; #1;
      chk("stall.wb", o_wb, 32'hCAFE_F00D);
      check_outputs("stall");
    end
    en = 1'b1;

    // Flush with enable low inserts a bubble
    set_instr(1'b1, 1'b0, 2'd0, 1'b0, 5'd8, 32'h0000_0042);
    fl = 1'b1; en = 1'b0;
    tick();
    fl = 1'b0; en = 1'b1; #1;
    chk("flush.we", {31'd0, o_rw}, 32'd0);
    chk("flush.wb", o_wb, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) != 0);
      rw  = $urandom_range(0, 1) != 0;
      mtr = $urandom_range(0, 2) != 0;
      sz  = 2'($urandom_range(0, 3));
      uns = $urandom_range(0, 1) != 0;
      rd  = 5'($urandom);
      alu = $urandom;
      if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
      mem = $urandom;
      #1;
      check_outputs("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
